// File: rtl/sonar_pkg.sv
// Shared sonar definitions: sweep FSM state codes and servo position range.
package sonar_pkg;

  localparam int POS_W = 3;
  localparam logic [POS_W-1:0] POS_MAX = 3'd7;

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    POSICIONA = 3'd1,
    MEDE      = 3'd2,
    AGUARDA   = 3'd3,
    REGISTRA  = 3'd4,
    ERRO      = 3'd5,
    PROXIMO   = 3'd6
  } estado_t;

endpackage

// File: rtl/contador_ciclos.sv
// Cycle counter with a run-time modulus; fim is high on the modulus-th counted cycle.
// Saturates at modulus-1 instead of wrapping; synchronous clear has priority over enable.
module contador_ciclos #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         limpar,
  input  logic         habilitar,
  input  logic [W-1:0] modulo,
  output logic         fim
);

  logic [W-1:0] contagem;

  assign fim = (contagem >= modulo - W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (limpar) begin
      contagem <= '0;
    end else if (habilitar && !fim) begin
      contagem <= contagem + W'(1);
    end
  end

endmodule

// File: rtl/controle_varredura.sv
// Sonar sweep sequencer: bounce servo over 0..7, settle, request a range, report result or timeout.
// Point period SETTLE+4 cycles (SETTLE+TIMEOUT+3 on timeout); ligar is only honoured between points.
module controle_varredura
  import sonar_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 5_000_000,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             pronto_medida,
  output logic [POS_W-1:0] posicao,
  output logic             medir,
  output logic             ponto_valido,
  output logic             erro_timeout,
  output logic [2:0]       db_estado
);

  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  estado_t          estado;
  logic             subindo;
  logic             contar;
  logic             fim;
  logic [CNT_W-1:0] modulo;
  logic [POS_W-1:0] proxima_pos;

  // Only the two timed states count; every other state holds the counter at
  // zero, so each entry into a timed state starts from a clean count.
  assign contar = (estado == POSICIONA) || (estado == AGUARDA);
  assign modulo = (estado == POSICIONA) ? CNT_W'(SETTLE_CYCLES) : CNT_W'(TIMEOUT_CYCLES);

  contador_ciclos #(
    .W (CNT_W)
  ) u_contador (
    .clock     (clock),
    .reset     (reset),
    .limpar    (!contar),
    .habilitar (contar),
    .modulo    (modulo),
    .fim       (fim)
  );

  assign proxima_pos = subindo ? posicao + POS_W'(1) : posicao - POS_W'(1);
  assign db_estado   = estado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= INICIAL;
      posicao      <= '0;
      subindo      <= 1'b1;
      medir        <= 1'b0;
      ponto_valido <= 1'b0;
      erro_timeout <= 1'b0;
    end else begin
      medir        <= 1'b0;
      ponto_valido <= 1'b0;
      erro_timeout <= 1'b0;
      case (estado)
        INICIAL: begin
          if (ligar) estado <= POSICIONA;
        end
        POSICIONA: begin
          if (fim) begin
            estado <= MEDE;
            medir  <= 1'b1;
          end
        end
        MEDE: begin
          estado <= AGUARDA;
        end
        AGUARDA: begin
          // A completion arriving on the timeout cycle still counts as valid.
          if (pronto_medida) begin
            estado       <= REGISTRA;
            ponto_valido <= 1'b1;
          end else if (fim) begin
            estado       <= ERRO;
            erro_timeout <= 1'b1;
          end
        end
        REGISTRA, ERRO: begin
          estado <= PROXIMO;
        end
        PROXIMO: begin
          posicao <= proxima_pos;
          if (subindo && proxima_pos == POS_MAX) begin
            subindo <= 1'b0;
          end else if (!subindo && proxima_pos == '0) begin
            subindo <= 1'b1;
          end
          estado <= ligar ? POSICIONA : INICIAL;
        end
        default: begin
          estado <= INICIAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_varredura.sv
// Self-checking bench for controle_varredura with SETTLE_CYCLES=4, TIMEOUT_CYCLES=8.
module tb_controle_varredura;

  localparam int S = 4;
  localparam int T = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       ligar;
  logic       pronto_medida;
  logic [2:0] posicao;
  logic       medir;
  logic       ponto_valido;
  logic       erro_timeout;
  logic [2:0] db_estado;

  int total = 0;
  int bad   = 0;
  int n     = 0;   // index of the next point in the bouncing sweep

  always #5 clock = ~clock;

  controle_varredura #(
    .SETTLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ligar         (ligar),
    .pronto_medida (pronto_medida),
    .posicao       (posicao),
    .medir         (medir),
    .ponto_valido  (ponto_valido),
    .erro_timeout  (erro_timeout),
    .db_estado     (db_estado)
  );

  // Triangle wave of period 14: 0,1,..,7,6,..,1,0,1,...
  function automatic logic [2:0] sweep_pos(input int k);
    int m;
    m = k % 14;
    return (m <= 7) ? 3'(m) : 3'(14 - m);
  endfunction

  // One sweep point, starting from the negedge just before POSICIONA begins.
  // d: AGUARDA cycle (1..T) on which pronto_medida is driven; 0 means never.
  task automatic run_point(input int d, input bit stray, input bit drop);
    int k, stray_k, spurious, exp_evt, evt_v, evt_e, vld_cnt, err_cnt;
    bit seen, exp_ok, pos_bad, extra_medir;
    logic [2:0] pos_exp, st_end;
    pos_exp  = sweep_pos(n);
    stray_k  = stray ? int'($urandom_range(S, 1)) : 0;
    seen     = 1'b0;
    k        = 0;
    spurious = 0;
    while (!seen && k < S + 12) begin
      @(negedge clock);
      k++;
      if (medir) seen = 1'b1;
      if (ponto_valido || erro_timeout) spurious++;
      pronto_medida = stray && (k == stray_k);
    end
    pronto_medida = 1'b0;
    total++;
    if (!seen || k != S + 1) begin
      bad++;
      $display("FAIL medir_latency pt%0d: got %0d cycles (seen=%0b) want %0d", n, k, seen, S + 1);
    end
    total++;
    if (posicao !== pos_exp) begin
      bad++;
      $display("FAIL posicao_at_medir pt%0d: got %0d want %0d", n, posicao, pos_exp);
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL settle_pulses pt%0d: got %0d result pulses want 0", n, spurious);
    end

    exp_ok      = (d >= 1 && d <= T);
    exp_evt     = exp_ok ? d + 1 : T + 1;
    evt_v       = 0;
    evt_e       = 0;
    vld_cnt     = 0;
    err_cnt     = 0;
    pos_bad     = 1'b0;
    extra_medir = 1'b0;
    st_end      = 3'd0;
    for (int i = 1; i <= exp_evt + 1; i++) begin
      @(negedge clock);
      if (ponto_valido) begin
        vld_cnt++;
        if (evt_v == 0) evt_v = i;
      end
      if (erro_timeout) begin
        err_cnt++;
        if (evt_e == 0) evt_e = i;
      end
      if (posicao !== pos_exp) pos_bad = 1'b1;
      if (medir) extra_medir = 1'b1;
      st_end = db_estado;
      pronto_medida = (i == d);
      if (drop && i == 1) ligar = 1'b0;
    end
    pronto_medida = 1'b0;

    total++;
    if (vld_cnt != (exp_ok ? 1 : 0) || (exp_ok && evt_v != exp_evt)) begin
      bad++;
      $display("FAIL ponto_valido pt%0d: got %0d pulses at cycle %0d want %0d at cycle %0d",
               n, vld_cnt, evt_v, exp_ok ? 1 : 0, exp_ok ? exp_evt : 0);
    end
    total++;
    if (err_cnt != (exp_ok ? 0 : 1) || (!exp_ok && evt_e != exp_evt)) begin
      bad++;
      $display("FAIL erro_timeout pt%0d: got %0d pulses at cycle %0d want %0d at cycle %0d",
               n, err_cnt, evt_e, exp_ok ? 0 : 1, exp_ok ? 0 : exp_evt);
    end
    total++;
    if (pos_bad || extra_medir) begin
      bad++;
      $display("FAIL result_window pt%0d: got pos_changed=%0b extra_medir=%0b want 0 0", n, pos_bad, extra_medir);
    end
    total++;
    if (st_end !== 3'd6) begin
      bad++;
      $display("FAIL proximo_state pt%0d: got %0d want 6", n, st_end);
    end
    n++;
  endtask

  // After a point completed with ligar low: idle in INICIAL, ignore pronto, then resume.
  task automatic test_idle_resume;
    int viol;
    @(negedge clock);
    total++;
    if (db_estado !== 3'd0) begin
      bad++;
      $display("FAIL idle_state: got %0d want 0", db_estado);
    end
    total++;
    if (posicao !== sweep_pos(n)) begin
      bad++;
      $display("FAIL idle_posicao: got %0d want %0d", posicao, sweep_pos(n));
    end
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      pronto_medida = (i == 1);
      @(negedge clock);
      if (db_estado !== 3'd0 || ponto_valido || medir) viol++;
    end
    pronto_medida = 1'b0;
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL idle_stray: got %0d bad cycles want 0", viol);
    end
    ligar = 1'b1;
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    ligar         = 1'b0;
    pronto_medida = 1'b0;
    #1;
    total++;
    if (posicao !== 3'd0 || db_estado !== 3'd0) begin
      bad++;
      $display("FAIL reset_regs: got pos=%0d st=%0d want 0 0", posicao, db_estado);
    end
    total++;
    if ({medir, ponto_valido, erro_timeout} !== 3'b000) begin
      bad++;
      $display("FAIL reset_pulses: got %b want 000", {medir, ponto_valido, erro_timeout});
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    total++;
    if (db_estado !== 3'd0) begin
      bad++;
      $display("FAIL idle_without_ligar: got %0d want 0", db_estado);
    end
  endtask

  task automatic test_full_sweep;
    ligar = 1'b1;
    for (int i = 0; i < 16; i++) run_point(2, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    run_point(2, 1'b0, 1'b0);   // position 2
    run_point(0, 1'b0, 1'b0);   // position 3, never answered
    run_point(2, 1'b0, 1'b0);   // position 4
  endtask

  task automatic test_simultaneous;
    run_point(T, 1'b0, 1'b0);   // pronto on the last AGUARDA cycle
  endtask

  task automatic test_stop_resume;
    for (int i = 0; i < 3; i++) run_point(int'($urandom_range(T, 1)), 1'b0, 1'b0);
    run_point(2, 1'b0, 1'b1);   // position 5 heading down, ligar dropped in AGUARDA
    test_idle_resume();
    run_point(2, 1'b1, 1'b0);
    run_point(2, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    bit drop;
    for (int i = 0; i < 30; i++) begin
      drop = ($urandom_range(5, 0) == 0);
      run_point(int'($urandom_range(T, 0)), $urandom_range(1, 0) == 1, drop);
      if (drop) test_idle_resume();
    end
  endtask

  task automatic test_reset_mid;
    int k, viol;
    bit seen;
    seen = 1'b0;
    k    = 0;
    while (!seen && k < 40) begin
      @(negedge clock);
      k++;
      if (medir) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL reset_mid_wait: got no medir in %0d cycles want medir", k);
    end
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total++;
    if (posicao !== 3'd0 || db_estado !== 3'd0 ||
        {medir, ponto_valido, erro_timeout} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid: got pos=%0d st=%0d pulses=%b want 0 0 000",
               posicao, db_estado, {medir, ponto_valido, erro_timeout});
    end
    ligar = 1'b0;
    @(negedge clock);
    pronto_medida = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    viol  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      pronto_medida = 1'b0;
      if (db_estado !== 3'd0 || ponto_valido || erro_timeout) viol++;
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL reset_pronto_ignored: got %0d bad cycles want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_timeout();
    test_simultaneous();
    test_stop_resume();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
